// File: rtl/counter_seq_ctrl.sv
// Start/pause/stop sequencer with programmable tick prescaler for the 0-99 count datapath.
// Define COUNTER_SEQ_AUTORELOAD_EN to re-preset and keep running on a target match instead of entering DONE.
module counter_seq_ctrl #(
  parameter int unsigned TICK_DIV = 32'd100000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic       dir_req,
  input  logic       target_en,
  input  logic [7:0] target,
  input  logic [7:0] count,
  output logic       tick,
  output logic       updown,
  output logic       clr,
  output logic       busy,
  output logic       done,
  output logic [1:0] state
);

  localparam int unsigned PW = (TICK_DIV > 32'd2) ? $clog2(TICK_DIV) : 32'd1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  state_e        state_r, state_n;
  logic [PW-1:0] presc_r, presc_n;
  logic          updown_r, updown_n;
  logic          clr_r, clr_n;
  logic          done_r, done_n;
  logic          busy_r, busy_n;
  logic          tick_s;
  logic          match_s;
  logic [7:0]    nxt_s;

  assign tick_s = (state_r == ST_RUN) && (presc_r == PRESC_MAX);

  // Value the datapath will hold after the next tick, used for target matching
  always_comb begin
    nxt_s = 8'd0;
    if (updown_r) begin
      if (count >= 8'd99) nxt_s = 8'd0;
      else                nxt_s = count + 8'd1;
    end else begin
      if (count == 8'd0)  nxt_s = 8'd99;
      else                nxt_s = count - 8'd1;
    end
  end

  assign match_s = tick_s && target_en && (nxt_s == target);

  // Next-state, prescaler and registered-output decode; stop beats start beats pause
  always_comb begin
    state_n  = state_r;
    presc_n  = presc_r;
    updown_n = updown_r;
    clr_n    = 1'b0;
    done_n   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        updown_n = dir_req;
        if (!stop && start) begin
          state_n = ST_RUN;
          presc_n = {PW{1'b0}};
          clr_n   = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (tick_s) presc_n = {PW{1'b0}};
        else        presc_n = presc_r + PW'(1);
        if (stop) begin
          state_n = ST_IDLE;
        end else if (start) begin
          state_n = ST_RUN;
          presc_n = {PW{1'b0}};
          clr_n   = 1'b1;
        end else if (match_s) begin
          done_n  = 1'b1;
`ifdef COUNTER_SEQ_AUTORELOAD_EN
          state_n = ST_RUN;
          presc_n = {PW{1'b0}};
          clr_n   = 1'b1;
`else
          state_n = ST_DONE;
`endif
        end else if (pause) begin
          state_n = ST_PAUSE;
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_PAUSE: begin
        // Prescaler holds here so the interrupted period resumes where it left off
        updown_n = dir_req;
        if (stop) begin
          state_n = ST_IDLE;
        end else if (start) begin
          state_n = ST_RUN;
          presc_n = {PW{1'b0}};
          clr_n   = 1'b1;
        end else if (pause) begin
          state_n = ST_RUN;
        end else begin
          state_n = ST_PAUSE;
        end
      end
      ST_DONE: begin
        if (stop) begin
          state_n = ST_IDLE;
        end else if (start) begin
          state_n = ST_RUN;
          presc_n = {PW{1'b0}};
          clr_n   = 1'b1;
        end else begin
          state_n = ST_DONE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        presc_n = {PW{1'b0}};
      end
    endcase
    busy_n = (state_n == ST_RUN) || (state_n == ST_PAUSE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      presc_r  <= {PW{1'b0}};
      updown_r <= 1'b1;
      clr_r    <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      presc_r  <= presc_n;
      updown_r <= updown_n;
      clr_r    <= clr_n;
      done_r   <= done_n;
      busy_r   <= busy_n;
    end
  end

  assign tick   = tick_s;
  assign updown = updown_r;
  assign clr    = clr_r;
  assign done   = done_r;
  assign busy   = busy_r;
  assign state  = state_r;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Table-driven bench for counter_seq_ctrl with TICK_DIV=4 and a behavioural 0-99 datapath.
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, pause, stop, dir_req, target_en;
  logic [7:0] target;
  logic [7:0] count_m;
  logic       tick, updown, clr, busy, done;
  logic [1:0] state;
  int         tick_cnt;
  int         n_cmp = 0;
  int         n_bad = 0;

  typedef struct {
    logic       start, pause, stop, dir_req, target_en;
    logic [7:0] target;
    logic [1:0] e_state;
    logic       e_tick, e_clr, e_busy, e_done, e_updown;
    logic [7:0] e_count;
  } row_t;

  row_t tbl[$];
  row_t exp_q[$];

  counter_seq_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .stop(stop),
    .dir_req(dir_req), .target_en(target_en), .target(target), .count(count_m),
    .tick(tick), .updown(updown), .clr(clr), .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  // Datapath model driven by the controller's outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_m  <= 8'd0;
      tick_cnt <= 0;
    end else if (clr) begin
      count_m  <= updown ? 8'd0 : 8'd99;
      tick_cnt <= 0;
    end else if (tick) begin
      if (updown) count_m <= (count_m == 8'd99) ? 8'd0 : count_m + 8'd1;
      else        count_m <= (count_m == 8'd0) ? 8'd99 : count_m - 8'd1;
      tick_cnt <= tick_cnt + 1;
    end
  end

  function automatic row_t mk(input logic s, input logic p, input logic sp, input logic d,
                              input logic te, input logic [7:0] tg, input logic [1:0] es,
                              input logic et, input logic ec, input logic eb, input logic ed,
                              input logic eu, input logic [7:0] cnt);
    row_t r;
    r.start = s; r.pause = p; r.stop = sp; r.dir_req = d; r.target_en = te; r.target = tg;
    r.e_state = es; r.e_tick = et; r.e_clr = ec; r.e_busy = eb; r.e_done = ed;
    r.e_updown = eu; r.e_count = cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int idx);
    row_t r;
    r = tbl[idx];
    start = r.start; pause = r.pause; stop = r.stop;
    dir_req = r.dir_req; target_en = r.target_en; target = r.target;
    exp_q.push_back(r);
    @(posedge clk);
    #1;
    r = exp_q.pop_front();
    chk($sformatf("row%0d state", idx), {30'd0, state}, {30'd0, r.e_state});
    chk($sformatf("row%0d tick", idx), {31'd0, tick}, {31'd0, r.e_tick});
    chk($sformatf("row%0d clr", idx), {31'd0, clr}, {31'd0, r.e_clr});
    chk($sformatf("row%0d busy", idx), {31'd0, busy}, {31'd0, r.e_busy});
    chk($sformatf("row%0d done", idx), {31'd0, done}, {31'd0, r.e_done});
    chk($sformatf("row%0d updown", idx), {31'd0, updown}, {31'd0, r.e_updown});
    if (r.e_count != 8'hFF) chk($sformatf("row%0d count", idx), {24'd0, count_m}, {24'd0, r.e_count});
  endtask

  initial begin
    int idx_wrap;
    int idx_end;
    bit found;

    reset_n = 1'b0;
    start = 1'b0; pause = 1'b0; stop = 1'b0; dir_req = 1'b1; target_en = 1'b0; target = 8'd0;

    // Free-running up start
    tbl.push_back(mk(0,0,0,1,0,8'd0,  2'd0,0,0,0,0,1, 8'd0));
    tbl.push_back(mk(0,0,0,0,0,8'd0,  2'd0,0,0,0,0,0, 8'd0));
    tbl.push_back(mk(1,0,0,1,0,8'd0,  2'd1,0,1,1,0,1, 8'd0));
    tbl.push_back(mk(0,0,0,1,0,8'd0,  2'd1,0,0,1,0,1, 8'd0));
    tbl.push_back(mk(0,0,0,1,0,8'd0,  2'd1,0,0,1,0,1, 8'd0));
    tbl.push_back(mk(0,0,0,1,0,8'd0,  2'd1,1,0,1,0,1, 8'd0));
    tbl.push_back(mk(0,0,0,1,0,8'd0,  2'd1,0,0,1,0,1, 8'd1));
    tbl.push_back(mk(0,0,0,1,0,8'd0,  2'd1,0,0,1,0,1, 8'd1));
    tbl.push_back(mk(0,0,0,1,0,8'd0,  2'd1,0,0,1,0,1, 8'd1));
    tbl.push_back(mk(0,0,0,1,0,8'd0,  2'd1,1,0,1,0,1, 8'd1));
    tbl.push_back(mk(0,0,0,1,0,8'd0,  2'd1,0,0,1,0,1, 8'd2));
    idx_wrap = tbl.size();
    // Pause at prescaler 2, flip direction while paused, resume
    tbl.push_back(mk(1,0,0,1,0,8'd0,  2'd1,0,1,1,0,1, 8'hFF));
    tbl.push_back(mk(0,0,0,1,0,8'd0,  2'd1,0,0,1,0,1, 8'd0));
    tbl.push_back(mk(0,0,0,1,0,8'd0,  2'd1,0,0,1,0,1, 8'd0));
    tbl.push_back(mk(0,1,0,1,0,8'd0,  2'd2,0,0,1,0,1, 8'd0));
    tbl.push_back(mk(0,0,0,0,0,8'd0,  2'd2,0,0,1,0,0, 8'd0));
    tbl.push_back(mk(0,0,0,0,0,8'd0,  2'd2,0,0,1,0,0, 8'd0));
    tbl.push_back(mk(0,1,0,0,0,8'd0,  2'd1,1,0,1,0,0, 8'd0));
    tbl.push_back(mk(0,0,0,1,0,8'd0,  2'd1,0,0,1,0,0, 8'd99));
    // stop+start together, then pause on the tick cycle
    tbl.push_back(mk(1,0,1,1,0,8'd0,  2'd0,0,0,0,0,0, 8'd99));
    tbl.push_back(mk(0,0,0,1,0,8'd0,  2'd0,0,0,0,0,1, 8'd99));
    tbl.push_back(mk(1,0,0,1,0,8'd0,  2'd1,0,1,1,0,1, 8'd99));
    tbl.push_back(mk(0,0,0,1,0,8'd0,  2'd1,0,0,1,0,1, 8'd0));
    tbl.push_back(mk(0,0,0,1,0,8'd0,  2'd1,0,0,1,0,1, 8'd0));
    tbl.push_back(mk(0,0,0,1,0,8'd0,  2'd1,1,0,1,0,1, 8'd0));
    tbl.push_back(mk(0,1,0,1,0,8'd0,  2'd2,0,0,1,0,1, 8'd1));
    tbl.push_back(mk(0,0,1,1,0,8'd0,  2'd0,0,0,0,0,1, 8'd1));
    // Down count to target 95
    tbl.push_back(mk(1,0,0,0,1,8'd95, 2'd1,0,1,1,0,0, 8'd1));
    for (int k = 1; k <= 15; k++)
      tbl.push_back(mk(0,0,0,0,1,8'd95, 2'd1,((k % 4) == 3),0,1,0,0, 8'(99 - k / 4)));
`ifdef COUNTER_SEQ_AUTORELOAD_EN
    tbl.push_back(mk(0,0,0,0,1,8'd95, 2'd1,0,1,1,1,0, 8'd95));
    tbl.push_back(mk(0,0,0,0,1,8'd95, 2'd1,0,0,1,0,0, 8'd99));
    tbl.push_back(mk(0,0,0,0,1,8'd50, 2'd1,0,0,1,0,0, 8'd99));
    tbl.push_back(mk(0,0,1,0,1,8'd50, 2'd0,0,0,0,0,0, 8'd99));
`else
    tbl.push_back(mk(0,0,0,0,1,8'd95, 2'd3,0,0,0,1,0, 8'd95));
    tbl.push_back(mk(0,0,0,0,1,8'd95, 2'd3,0,0,0,0,0, 8'd95));
    tbl.push_back(mk(0,0,0,0,1,8'd50, 2'd3,0,0,0,0,0, 8'd95));
    tbl.push_back(mk(0,0,1,0,1,8'd50, 2'd0,0,0,0,0,0, 8'd95));
`endif
    tbl.push_back(mk(1,0,0,1,0,8'd0,  2'd1,0,1,1,0,1, 8'hFF));
    idx_end = tbl.size();

    repeat (3) @(posedge clk);
    #1;
    chk("reset state", {30'd0, state}, 32'd0);
    chk("reset updown", {31'd0, updown}, 32'd1);
    chk("reset tick", {31'd0, tick}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < idx_wrap; i++) step(i);

    // Run until the count reaches 99, then confirm it wraps to 0 on the 100th tick
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(posedge clk);
      #1;
      if (count_m == 8'd99) found = 1'b1;
    end
    chk("reach 99", {31'd0, found}, 32'd1);
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(posedge clk);
      #1;
      if (count_m != 8'd99) found = 1'b1;
    end
    chk("wrap seen", {31'd0, found}, 32'd1);
    chk("wrap value", {24'd0, count_m}, 32'd0);
    chk("ticks to wrap", tick_cnt, 32'd100);

    for (int i = idx_wrap; i < idx_end; i++) step(i);
    start = 1'b0; pause = 1'b0; stop = 1'b0; dir_req = 1'b1; target_en = 1'b0;

    // Asynchronous reset while clr is high in RUN
    #2;
    reset_n = 1'b0;
    #1;
    chk("async rst state", {30'd0, state}, 32'd0);
    chk("async rst clr", {31'd0, clr}, 32'd0);
    chk("async rst tick", {31'd0, tick}, 32'd0);
    chk("async rst updown", {31'd0, updown}, 32'd1);
    chk("async rst busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post rst state", {30'd0, state}, 32'd0);
    chk("post rst busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
